// File: rtl/mac_unit.sv
// Single-stage multiply-accumulate cell for a MAC chain: out = x * w + previous_out, registered.
// Optional MAC_SATURATE_EN clamps out to the signed 8-bit range instead of wrapping.
module mac_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] x,
  input  logic [7:0] w,
  input  logic [7:0] previous_out,
  input  logic       in_valid,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       ovf
);

  logic signed [12:0] product;
  logic signed [12:0] sum;
  logic               sum_ovf;
  logic        [7:0]  result;

  logic [7:0] out_d,       out_q;
  logic       out_valid_d, out_valid_q;
  logic       ovf_d,       ovf_q;

  // 13 bits hold both the product (-1920..1905) and the sum (-2048..2032) exactly.
  assign product = $signed({9'b0, x}) * $signed({{5{w[7]}}, w});
  assign sum     = product + $signed({{5{previous_out[7]}}, previous_out});

  // The sum fits in 8 bits only if its upper bits all replicate bit 7.
  assign sum_ovf = (sum[12:7] != {6{sum[7]}});

`ifdef MAC_SATURATE_EN
  assign result = sum_ovf ? (sum[12] ? 8'h80 : 8'h7F) : sum[7:0];
`else
  assign result = sum[7:0];
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    out_d       = out_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_d       = result;
      ovf_d       = sum_ovf;
      out_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_unit.sv
// Directed self-checking bench for mac_unit; expected values are hand-computed per vector.
// Define MAC_SATURATE_EN for both RTL and bench to check the saturating build.
module tb_mac_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic [7:0] w;
  logic [7:0] previous_out;
  logic       in_valid;
  logic [7:0] out;
  logic       out_valid;
  logic       ovf;

  int n_checks = 0;
  int n_fails  = 0;

  mac_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x            (x),
    .w            (w),
    .previous_out (previous_out),
    .in_valid     (in_valid),
    .out          (out),
    .out_valid    (out_valid),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $display("FAIL %s: observed 0x%02h expected 0x%02h", tag, got, exp);
      $error("%s observed 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Apply operands on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic [3:0] xi, input logic [7:0] wi, input logic [7:0] pi,
                      input logic vi);
    @(negedge clk);
    x = xi; w = wi; previous_out = pi; in_valid = vi;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_out, input logic e_vld,
                           input logic e_ovf);
    check({tag, ".out"},       out,             e_out);
    check({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, e_vld});
    check({tag, ".ovf"},       {7'b0, ovf},       {7'b0, e_ovf});
  endtask

  initial begin
    rst_n = 1'b0; x = '0; w = '0; previous_out = '0; in_valid = 1'b0;
    #12;
    check_out("reset", 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    step(4'd2, 8'd4, 8'd0, 1'b1);                 // 2*4+0 = 8
    check_out("basic", 8'd8, 1'b1, 1'b0);

    step(4'd3, 8'd9, 8'd8, 1'b1);                 // 27+8 = 35, back-to-back
    check_out("chain", 8'd35, 1'b1, 1'b0);

    step(4'd7, 8'd7, 8'd7, 1'b0);
    check_out("hold", 8'd35, 1'b0, 1'b0);

    step(4'd5, 8'hF9, 8'd10, 1'b1);               // -35+10 = -25
    check_out("negative", 8'hE7, 1'b1, 1'b0);

    step(4'd15, 8'd127, 8'd127, 1'b1);            // 2032 = 0x7F0
`ifdef MAC_SATURATE_EN
    check_out("overflow", 8'h7F, 1'b1, 1'b1);
`else
    check_out("overflow", 8'hF0, 1'b1, 1'b1);
`endif

    step(4'd0, 8'd0, 8'd0, 1'b0);
`ifdef MAC_SATURATE_EN
    check_out("ovf_hold", 8'h7F, 1'b0, 1'b1);
`else
    check_out("ovf_hold", 8'hF0, 1'b0, 1'b1);
`endif

    step(4'd15, 8'h80, 8'h80, 1'b1);              // -2048 = 0x800 (low byte 0x00)
`ifdef MAC_SATURATE_EN
    check_out("underflow", 8'h80, 1'b1, 1'b1);
`else
    check_out("underflow", 8'h00, 1'b1, 1'b1);
`endif

    step(4'd0, 8'h55, 8'h9C, 1'b1);               // x=0 passes previous_out through
    check_out("x_zero", 8'h9C, 1'b1, 1'b0);

    step(4'd1, 8'd0, 8'd127, 1'b1);               // 127: top edge, no overflow
    check_out("edge_hi", 8'h7F, 1'b1, 1'b0);

    step(4'd1, 8'd1, 8'd127, 1'b1);               // 128: just over
`ifdef MAC_SATURATE_EN
    check_out("over_hi", 8'h7F, 1'b1, 1'b1);
`else
    check_out("over_hi", 8'h80, 1'b1, 1'b1);
`endif

    step(4'd1, 8'hFF, 8'h80, 1'b1);               // -129: just under
`ifdef MAC_SATURATE_EN
    check_out("over_lo", 8'h80, 1'b1, 1'b1);
`else
    check_out("over_lo", 8'h7F, 1'b1, 1'b1);
`endif

    step(4'd3, 8'd9, 8'd8, 1'b1);
    check_out("rechain", 8'd35, 1'b1, 1'b0);

    // Asynchronous reset between edges, held across an edge with in_valid high.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 8'h00, 1'b0, 1'b0);
    step(4'd4, 8'd4, 8'd4, 1'b1);
    check_out("rst_hold", 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    x = 4'd1; w = 8'd1; previous_out = 8'd1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_rst", 8'd2, 1'b1, 1'b0);

    step(4'd0, 8'd0, 8'd0, 1'b0);
    check_out("post_idle", 8'd2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
